// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and enums for the register file write-port controller
package rf_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef enum logic {CLEAR, RUN} state_e;
    typedef enum logic {SRC_ALU, SRC_LSU} src_e;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin arbiter with last-winner pointer
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu
);
    src_e last_q, last_d;

    // On a tie the source that did not win last time goes first.
    always_comb begin
        gnt_alu = en && req_alu && (!req_lsu || last_q == SRC_LSU);
        gnt_lsu = en && req_lsu && (!req_alu || last_q == SRC_ALU);
        last_d  = last_q;
        if (gnt_alu)
            last_d = SRC_ALU;
        else if (gnt_lsu)
            last_d = SRC_LSU;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_q <= SRC_LSU;
        else
            last_q <= last_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write port: post-reset clear sweep then ALU/LSU writeback arbitration
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int NREG   = rf_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              init_busy
);
    state_e            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic              regwrite_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] write_data_q;
    logic              gnt_alu, gnt_lsu;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q == RUN),
        .req_alu (alu_valid),
        .req_lsu (lsu_valid),
        .gnt_alu (gnt_alu),
        .gnt_lsu (gnt_lsu)
    );

    // Grants are already qualified by valid, so a grant is a transfer.
    assign alu_ready  = gnt_alu;
    assign lsu_ready  = gnt_lsu;
    assign init_busy  = (state_q == CLEAR);
    assign RegWrite   = regwrite_q;
    assign rd_addr    = rd_addr_q;
    assign write_data = write_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            regwrite_q   <= 1'b0;
            rd_addr_q    <= '0;
            write_data_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    regwrite_q   <= 1'b1;
                    rd_addr_q    <= cnt_q[ADDR_W-1:0];
                    write_data_q <= '0;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == (ADDR_W+1)'(NREG - 1))
                        state_q <= RUN;
                end
                RUN: begin
                    regwrite_q <= 1'b0;
                    // x0 writes are accepted but never reach the array.
                    if (gnt_alu) begin
                        regwrite_q   <= (alu_rd != '0);
                        rd_addr_q    <= alu_rd;
                        write_data_q <= alu_data;
                    end else if (gnt_lsu) begin
                        regwrite_q   <= (lsu_rd != '0);
                        rd_addr_q    <= lsu_rd;
                        write_data_q <= lsu_data;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32x32 integer register file. It sequences a post-reset clear sweep of all 32 registers. After the sweep it arbitrates between the ALU and load/store writeback sources with round-robin priority. It drives the register file's single write port (`RegWrite`, `rd_addr`, `write_data`) from registered outputs. The block sits between the execute/memory writeback stages and the register file.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width
- `NREG`, 32, register count swept during clear; equals 2^ADDR_W

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `lsu_valid`  in  1  load writeback request
- `lsu_ready`  out  1  load request accepted this cycle
- `lsu_rd`  in  ADDR_W  load destination register
- `lsu_data`  in  DATA_W  load data
- `RegWrite`  out  1  register file write enable
- `rd_addr`  out  ADDR_W  register file write index
- `write_data`  out  DATA_W  register file write data
- `init_busy`  out  1  clear sweep in progress; decode must stall

## Operation
- The FSM has two states: CLEAR and RUN.
- Reset puts the block in CLEAR with sweep counter `cnt`=0 and the round-robin pointer `last`=LSU, so the ALU wins the first tie.
- CLEAR:
  - Each cycle registers `RegWrite`=1, `rd_addr`=`cnt`, `write_data`=0, then increments `cnt`.
  - The cycle that issues `cnt`=NREG-1 moves the FSM to RUN.
  - Both `ready` outputs are held 0, and `valid` is ignored.
- RUN, arbitration:
  - Only one valid: that source is granted.
  - Both valid: the source not equal to `last` is granted.
  - Grant updates `last`.
- RUN, handshake:
  - `xxx_ready` is 1 only for the granted source, and only while its `valid` is 1.
  - A transfer occurs when `valid && ready`.
  - Outputs register the winner's rd and data, with `RegWrite`=1.
- x0 writes: a transfer with rd=0 is accepted (ready=1) but registers `RegWrite`=0. Architectural x0 stays zero.
- No transfer in RUN: `RegWrite`=0 is registered. `rd_addr`/`write_data` hold their previous values.
- Sources must hold `valid`, rd and data stable until ready. The arbiter never drops or reorders an accepted request.
- Readiness is combinational: `alu_ready`/`lsu_ready` are functions of both `valid`s, state and `last`. There is no ready-to-valid path.
- `init_busy` = (state==CLEAR), decoded from state.

## Timing
- During the `reset` cycle and on the first edge after it, the registered outputs are `RegWrite`=0, `rd_addr`=0, `write_data`=0. Combinational outputs: `init_busy`=1, `alu_ready`=`lsu_ready`=0.
- Clear sweep: first sweep write is visible after the first edge with `reset`=0. There are 32 consecutive `RegWrite` cycles covering rd 0..31.
- `init_busy` falls after the 32nd sweep edge. Ready may assert in that same cycle.
- Writeback latency: 1 cycle from handshake edge to `RegWrite`. The register file updates on the following edge, so data is readable 2 edges after handshake.
- Throughput: one write per cycle. Under continuous dual requests, grants alternate ALU, LSU, ALU, and so on.
- `reset` asserted mid-sweep or mid-RUN: on that edge the FSM returns to CLEAR with `cnt`=0 and `last`=LSU. `RegWrite` is registered 0 for that cycle. Any in-flight registered write is discarded.
- `cnt` is ADDR_W+1 bits wide so termination does not depend on wrap. `cnt` is never observed past NREG-1.

## Structure
- Shared package `rf_pkg`: `DATA_W`, `ADDR_W`, `NREG`, FSM state enum {CLEAR, RUN}, source enum {SRC_ALU, SRC_LSU}.
- Optional sub-module `rr_arb2`: a 2-request round-robin arbiter with `last`-pointer update on grant.
- The rest is a flat FSM plus output registers, instantiated beside `regfile`.

## Test plan
- Reset sweep: hold `reset` 3 cycles, then release. Expect 32 consecutive `RegWrite`=1 with `rd_addr` 0..31 and `write_data`=0. `init_busy` falls on cycle 32; both readies are 0 throughout.
- Single source: ALU writes rd=5, data=0xDEADBEEF. `alu_ready`=1 in the same cycle. Next cycle expect `RegWrite`=1, `rd_addr`=5, `write_data`=0xDEADBEEF. Register file x5 reads 0xDEADBEEF afterwards.
- Contention: both sources are valid for 4 cycles with distinct rd (ALU 1, 2; LSU 3, 4). Expect grants in the order ALU, LSU, ALU, LSU and writes to rd 1, 3, 2, 4 in that order.
- x0 write: LSU valid with rd=0, data=0x12345678. Expect `lsu_ready`=1 and `RegWrite`=0 the next cycle. x0 reads 0.
- Backpressure stability: LSU is held off by the ALU for one cycle and holds rd=7, data=0xA5A5A5A5. Exactly one write to x7 with that data occurs; there is no duplicate.
- Reset mid-operation: pulse `reset` during sweep cycle 10 and again during RUN traffic. Each time, a full 32-cycle sweep restarts from rd 0, and no pre-reset accepted write appears after the reset.
